// File: rtl/sha_1_pad.sv
// SHA-1 message padder: packs 32-bit words into 512-bit blocks, appends 0x80 marker and bit length.
// Define SHA_PAD_BYTE_EN to honour data_bytes on the final word; otherwise messages are whole words.
module sha_1_pad (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  data_in,
   input  logic         data_valid,
   input  logic         data_last,
   input  logic [2:0]   data_bytes,
   output logic         data_ready,
   output logic [511:0] Data,
   output logic [63:0]  Index,
   output logic         Enable,
   input  logic         Ready,
   output logic         msg_done
);

   typedef enum logic [1:0] {FILL, SEND, WAIT, PAD} state_t;

   state_t      state, state_nxt;
   logic [31:0] blk [16];
   logic [3:0]  wcnt;
   logic [63:0] bitcnt;
   logic        final_blk;
   logic        pad_pend;
   logic        pad_80;
   logic [2:0]  nb;
   logic [31:0] last_word;
   logic [63:0] len_nxt;
   logic [4:0]  occ;

`ifdef SHA_PAD_BYTE_EN
   assign nb = (data_bytes > 3'd4) ? 3'd4 : data_bytes;
`else
   logic unused_bytes;
   assign unused_bytes = ^data_bytes;
   assign nb = 3'd4;
`endif

   always_comb begin
      last_word = data_in;
      case (nb)
         3'd0:    last_word = 32'h8000_0000;
         3'd1:    last_word = {data_in[31:24], 24'h80_0000};
         3'd2:    last_word = {data_in[31:16], 16'h8000};
         3'd3:    last_word = {data_in[31:8], 8'h80};
         default: last_word = data_in;
      endcase
   end

   assign len_nxt = bitcnt + {58'd0, nb, 3'd0};
   // words occupied by data plus the 0x80 marker word when the last word is full
   assign occ = {1'b0, wcnt} + ((nb == 3'd4) ? 5'd2 : 5'd1);

   always_ff @(posedge clk) begin
      if (!rst) state <= FILL;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      data_ready = 1'b0;
      Enable     = 1'b0;
      msg_done   = 1'b0;
      case (state)
         FILL: begin
            data_ready = 1'b1;
            if (data_valid && (data_last || wcnt == 4'd15)) state_nxt = SEND;
         end
         SEND: begin
            Enable    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (Ready) begin
               msg_done  = final_blk;
               state_nxt = (!final_blk && pad_pend) ? PAD : FILL;
            end
         end
         PAD:     state_nxt = SEND;
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 16; i++) blk[i] <= '0;
         wcnt      <= '0;
         bitcnt    <= '0;
         Index     <= '0;
         final_blk <= 1'b0;
         pad_pend  <= 1'b0;
         pad_80    <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (data_valid) begin
                  if (!data_last) begin
                     blk[wcnt] <= data_in;
                     bitcnt    <= bitcnt + 64'd32;
                     wcnt      <= wcnt + 4'd1;
                     final_blk <= 1'b0;
                  end else begin
                     blk[wcnt] <= last_word;
                     bitcnt    <= len_nxt;
                     wcnt      <= '0;
                     if (nb == 3'd4 && wcnt != 4'd15) blk[wcnt + 4'd1] <= 32'h8000_0000;
                     if (occ <= 5'd14) begin
                        blk[14]   <= len_nxt[63:32];
                        blk[15]   <= len_nxt[31:0];
                        final_blk <= 1'b1;
                        pad_pend  <= 1'b0;
                     end else begin
                        final_blk <= 1'b0;
                        pad_pend  <= 1'b1;
                        pad_80    <= (nb == 3'd4) && (wcnt == 4'd15);
                     end
                  end
               end
            end
            WAIT: begin
               if (Ready) begin
                  Index <= final_blk ? '0 : Index + 64'd1;
                  if (final_blk) bitcnt <= '0;
                  if (final_blk || !pad_pend)
                     for (int unsigned i = 0; i < 16; i++) blk[i] <= '0;
               end
            end
            PAD: begin
               // bitcnt already holds the full message length here
               for (int unsigned i = 1; i < 14; i++) blk[i] <= '0;
               blk[0]    <= pad_80 ? 32'h8000_0000 : 32'h0;
               blk[14]   <= bitcnt[63:32];
               blk[15]   <= bitcnt[31:0];
               final_blk <= 1'b1;
               pad_pend  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Data = '0;
      for (int unsigned i = 0; i < 16; i++) Data[i*32 +: 32] = blk[i];
   end

endmodule
